// File: rtl/shift_collect_8_if.sv
// ============================================================================
//  shift_collect_8_if
//  Serial-bit input and byte-output handshake bundle for shift_collect_8.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface shift_collect_8_if;
  logic       start;
  logic       shift_in;
  logic       shift_en;
  logic       ready;
  logic       clr_err;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       overrun;

  modport master (
    output start, shift_in, shift_en, ready, clr_err,
    input  data_out, valid, busy, overrun
  );

  modport slave (
    input  start, shift_in, shift_en, ready, clr_err,
    output data_out, valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/shift_collect_8.sv
// ============================================================================
//  shift_collect_8
//  LSB-first serial-to-byte collector with a single holding register,
//  Valid/Ready output handshake and sticky overrun flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

module shift_collect_8 (
  input  logic            clk,
  input  logic            reset_n,
  shift_collect_8_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sr, sr_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] hold;
  logic       valid;
  logic       overrun;
  logic       byte_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= 8'h00;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Start has priority over a coincident shift, in either state.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    byte_done = 1'b0;
    if (bus.start) begin
      state_nxt = RECV;
      cnt_nxt   = 3'd0;
    end else if (state == RECV && bus.shift_en) begin
      sr_nxt  = {bus.shift_in, sr[7:1]};
      cnt_nxt = cnt + 3'd1;
      if (cnt == 3'd7) begin
        byte_done = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  // A completing byte may replace the held one only if it is consumed this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold    <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (byte_done) begin
        if (!valid || bus.ready) begin
          hold  <= sr_nxt;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && bus.ready) begin
        valid <= 1'b0;
      end

      if (!(byte_done && valid && !bus.ready) && bus.clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign bus.data_out = hold;
  assign bus.valid    = valid;
  assign bus.busy     = (state == RECV);
  assign bus.overrun  = overrun;

endmodule

`default_nettype wire
